// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, zero-register address and the
// write-queue entry type.
`default_nettype none

package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;

    localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wq_entry_t;

endpackage

`default_nettype wire

// File: rtl/wq_fwd_lookup.sv
// wq_fwd_lookup: youngest-first match of one read address against the
// write-queue entries, for read-after-write forwarding.
`default_nettype none

module wq_fwd_lookup
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] entry_data_i,
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [PTR_W-1:0]             tail_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            data_o
);

    // Walk oldest to youngest (tail-DEPTH .. tail-1) so the last match seen,
    // which is the youngest, is the one left on the outputs.
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        v_idx  = '0;
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            v_idx = tail_i - PTR_W'(k);
            if (valid_i[v_idx] && (entry_addr_i[v_idx] == rd_addr_i)) begin
                hit_o  = 1'b1;
                data_o = entry_data_i[v_idx];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order write-back FIFO in front of the 32x64 register
// file with RAW forwarding on both read ports. Option: REGFILE_XZR_DISCARD_EN.
`default_nettype none

module regfile_write_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     rf_hold,
    output logic                     W,
    output logic [ADDR_W-1:0]        DA,
    output logic [DATA_W-1:0]        D,
    input  logic [ADDR_W-1:0]        SA,
    input  logic [ADDR_W-1:0]        SB,
    output logic                     fwd_a_hit,
    output logic [DATA_W-1:0]        fwd_a_data,
    output logic                     fwd_b_hit,
    output logic [DATA_W-1:0]        fwd_b_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]              head_q, head_d;
    logic [PTR_W-1:0]              tail_q, tail_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0][ADDR_W-1:0]  addr_q;
    logic [DEPTH-1:0][DATA_W-1:0]  data_q;

    logic w_in_ready;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_nonempty;
    logic w_a_hit;
    logic w_b_hit;
    logic [DATA_W-1:0] w_a_data;
    logic [DATA_W-1:0] w_b_data;

    assign w_nonempty = (count_q != '0);
    assign w_in_ready = (count_q != FULL_CNT);
    assign w_accept   = in_valid && w_in_ready;
    assign w_pop      = w_nonempty && !rf_hold;

`ifdef REGFILE_XZR_DISCARD_EN
    // Writes to the zero register are acknowledged but never stored.
    assign w_push = w_accept && (in_addr != ADDR_W'(XZR_ADDR));
`else
    assign w_push = w_accept;
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (w_pop) begin
            head_d          = head_q + 1'b1;
            valid_d[head_q] = 1'b0;
        end
        if (w_push) begin
            tail_d          = tail_q + 1'b1;
            valid_d[tail_q] = 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            addr_q[tail_q] <= in_addr;
            data_q[tail_q] <= in_data;
        end
    end

    assign in_ready = w_in_ready;
    assign count    = count_q;
    assign W        = w_pop;
    assign DA       = w_nonempty ? addr_q[head_q] : '0;
    assign D        = w_nonempty ? data_q[head_q] : '0;

    wq_fwd_lookup #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_fwd_a (
        .entry_addr_i (addr_q),
        .entry_data_i (data_q),
        .valid_i      (valid_q),
        .tail_i       (tail_q),
        .rd_addr_i    (SA),
        .hit_o        (w_a_hit),
        .data_o       (w_a_data)
    );

    wq_fwd_lookup #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_fwd_b (
        .entry_addr_i (addr_q),
        .entry_data_i (data_q),
        .valid_i      (valid_q),
        .tail_i       (tail_q),
        .rd_addr_i    (SB),
        .hit_o        (w_b_hit),
        .data_o       (w_b_data)
    );

`ifdef REGFILE_XZR_DISCARD_EN
    logic w_sa_xzr;
    logic w_sb_xzr;
    assign w_sa_xzr   = (SA == ADDR_W'(XZR_ADDR));
    assign w_sb_xzr   = (SB == ADDR_W'(XZR_ADDR));
    assign fwd_a_hit  = w_a_hit && !w_sa_xzr;
    assign fwd_a_data = w_sa_xzr ? '0 : w_a_data;
    assign fwd_b_hit  = w_b_hit && !w_sb_xzr;
    assign fwd_b_data = w_sb_xzr ? '0 : w_b_data;
`else
    assign fwd_a_hit  = w_a_hit;
    assign fwd_a_data = w_a_data;
    assign fwd_b_hit  = w_b_hit;
    assign fwd_b_data = w_b_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: scoreboard bench for the register-file write queue.
`default_nettype none

module tb_regfile_write_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } sb_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_addr = '0;
    logic [63:0] in_data = '0;
    logic        rf_hold = 1'b0;
    logic        W;
    logic [4:0]  DA;
    logic [63:0] D;
    logic [4:0]  SA = '0;
    logic [4:0]  SB = '0;
    logic        fwd_a_hit;
    logic [63:0] fwd_a_data;
    logic        fwd_b_hit;
    logic [63:0] fwd_b_data;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    sb_t sb[$];

    regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(64), .ADDR_W(5)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .rf_hold(rf_hold), .W(W), .DA(DA), .D(D),
        .SA(SA), .SB(SB),
        .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
        .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
        .count(count)
    );

    always #5 clock = ~clock;

    function automatic bit discarded(input logic [4:0] a);
`ifdef REGFILE_XZR_DISCARD_EN
        return (a == 5'd31);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void fwd_model(input logic [4:0] a, output logic hit, output logic [63:0] d);
        hit = 1'b0;
        d   = '0;
        if (discarded(a)) return;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].a == a) begin
                hit = 1'b1;
                d   = sb[i].d;
                break;
            end
        end
    endfunction

    // One clock: scoreboard checks on the falling edge, returns 1 after the rising edge.
    task automatic step();
        int          n;
        logic        eh;
        logic [63:0] ed;
        logic        ew;
        sb_t         e;
        @(negedge clock);
        if (reset) begin
            n = sb.size();
            checks++;
            if (count !== 3'(n)) begin
                errors++; $display("FAIL count: got %0d want %0d", count, n);
            end
            checks++;
            if (in_ready !== (n != DEPTH)) begin
                errors++; $display("FAIL in_ready: got %b want %b", in_ready, (n != DEPTH));
            end
            ew = (n != 0) && !rf_hold;
            checks++;
            if (W !== ew) begin
                errors++; $display("FAIL W: got %b want %b", W, ew);
            end
            fwd_model(SA, eh, ed);
            checks++;
            if (fwd_a_hit !== eh || fwd_a_data !== ed) begin
                errors++; $display("FAIL fwd_a SA=%0d: got %b/%h want %b/%h", SA, fwd_a_hit, fwd_a_data, eh, ed);
            end
            fwd_model(SB, eh, ed);
            checks++;
            if (fwd_b_hit !== eh || fwd_b_data !== ed) begin
                errors++; $display("FAIL fwd_b SB=%0d: got %b/%h want %b/%h", SB, fwd_b_hit, fwd_b_data, eh, ed);
            end
            if (W === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL drain: got write DA=%0d D=%h want none", DA, D);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    if (DA !== e.a || D !== e.d) begin
                        errors++; $display("FAIL drain: got DA=%0d D=%h want DA=%0d D=%h", DA, D, e.a, e.d);
                    end
                end
            end else if (n == 0) begin
                checks++;
                if (DA !== 5'd0 || D !== 64'd0) begin
                    errors++; $display("FAIL empty_port: got DA=%0d D=%h want 0/0", DA, D);
                end
            end
            if (in_valid && in_ready && !discarded(in_addr))
                sb.push_back('{a: in_addr, d: in_data});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        rf_hold  = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL drain_timeout: got %0d left want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (W !== 1'b0 || DA !== 5'd0 || D !== 64'd0) begin
            errors++; $display("FAIL reset_port: got W=%b DA=%0d D=%h want 0", W, DA, D);
        end
        checks++;
        if (in_ready !== 1'b1 || count !== 3'd0) begin
            errors++; $display("FAIL reset_occ: got in_ready=%b count=%0d want 1/0", in_ready, count);
        end
        checks++;
        if (fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0 || fwd_a_data !== 64'd0 || fwd_b_data !== 64'd0) begin
            errors++; $display("FAIL reset_fwd: got %b %b %h %h want 0", fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        rf_hold  = 1'b0;
        in_valid = 1'b1; in_addr = 5'd3; in_data = 64'h11;
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (W !== 1'b1 || DA !== 5'd3 || D !== 64'h11) begin
            errors++; $display("FAIL single_write: got W=%b DA=%0d D=%h want 1/3/11", W, DA, D);
        end
        step();
        #1;
        checks++;
        if (W !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL single_after: got W=%b count=%0d want 0/0", W, count);
        end
    endtask

    task automatic test_hold_full();
        rf_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_addr = 5'(10 + i); in_data = 64'hA000 + 64'(i);
            step();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL full: got count=%0d in_ready=%b want 4/0", count, in_ready);
        end
        in_valid = 1'b1; in_addr = 5'd20; in_data = 64'hDEAD;
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd4) begin
            errors++; $display("FAIL fifth_push: got count=%0d want 4", count);
        end
        rf_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (W !== 1'b1 || DA !== 5'(10 + i) || D !== 64'hA000 + 64'(i)) begin
                errors++; $display("FAIL hold_release[%0d]: got W=%b DA=%0d D=%h want 1/%0d/%h", i, W, DA, D, 10 + i, 64'hA000 + 64'(i));
            end
            step();
        end
        #1;
        checks++;
        if (W !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL hold_empty: got W=%b count=%0d want 0/0", W, count);
        end
    endtask

    task automatic test_forward();
        rf_hold = 1'b1;
        SA = 5'd7; SB = 5'd8;
        in_valid = 1'b1; in_addr = 5'd7; in_data = 64'hA;
        step();
        in_data = 64'hB;
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (fwd_a_hit !== 1'b1 || fwd_a_data !== 64'hB) begin
            errors++; $display("FAIL fwd_youngest: got %b/%h want 1/b", fwd_a_hit, fwd_a_data);
        end
        checks++;
        if (fwd_b_hit !== 1'b0 || fwd_b_data !== 64'd0) begin
            errors++; $display("FAIL fwd_miss: got %b/%h want 0/0", fwd_b_hit, fwd_b_data);
        end
        drain();
        SA = 5'd0; SB = 5'd0;
    endtask

    task automatic test_back_to_back();
        int acc;
        int cyc;
        int p0;
        p0 = pops;
        rf_hold = 1'b1;
        SA = 5'd2; SB = 5'd5;
        for (acc = 0; acc < 4; acc++) begin
            in_valid = 1'b1; in_addr = 5'(acc % 8 + 1); in_data = 64'hB000 + 64'(acc);
            step();
        end
        rf_hold = 1'b0;
        cyc = 0;
        while (acc < 12 && cyc < 60) begin
            in_valid = 1'b1; in_addr = 5'(acc % 8 + 1); in_data = 64'hB000 + 64'(acc);
            #1;
            if (in_ready) acc++;
            checks++;
            if (W !== 1'b1) begin
                errors++; $display("FAIL b2b_pop cyc=%0d: got W=%b want 1", cyc, W);
            end
            step();
            cyc++;
        end
        drain();
        checks++;
        if (acc != 12 || (pops - p0) != 12) begin
            errors++; $display("FAIL b2b_total: got accepted=%0d pops=%0d want 12/12", acc, pops - p0);
        end
        SA = 5'd0; SB = 5'd0;
    endtask

    task automatic test_reset_mid();
        rf_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_addr = 5'(20 + i); in_data = 64'hC000 + 64'(i);
            step();
        end
        in_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (W !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid: got W=%b count=%0d in_ready=%b want 0/0/1", W, count, in_ready);
        end
        sb.delete();
        step();
        step();
        reset   = 1'b1;
        rf_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (W !== 1'b0) begin
                errors++; $display("FAIL reset_stale[%0d]: got W=%b DA=%0d want 0", i, W, DA);
            end
            step();
        end
    endtask

    task automatic test_xzr();
        rf_hold = 1'b1;
        SA = 5'd31;
        in_valid = 1'b1; in_addr = 5'd31; in_data = 64'h3131;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL xzr_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        #1;
`ifdef REGFILE_XZR_DISCARD_EN
        checks++;
        if (count !== 3'd0 || W !== 1'b0 || fwd_a_hit !== 1'b0) begin
            errors++; $display("FAIL xzr_discard: got count=%0d W=%b hit=%b want 0/0/0", count, W, fwd_a_hit);
        end
`else
        checks++;
        if (count !== 3'd1 || fwd_a_hit !== 1'b1 || fwd_a_data !== 64'h3131) begin
            errors++; $display("FAIL xzr_queued: got count=%0d hit=%b data=%h want 1/1/3131", count, fwd_a_hit, fwd_a_data);
        end
`endif
        drain();
        SA = 5'd0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold_full();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        test_xzr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_write_queue.md
# regfile_write_queue

Write-back queue sitting directly upstream of the 32x64 register file. Accepts destination writes (address + 64-bit data) from the execute/memory stages via valid/ready, buffers them in a small in-order FIFO, and drains at most one per cycle onto the register file's `W`/`DA`/`D` write port, pausing while `rf_hold` is high. Provides read-after-write forwarding on both read ports so consumers never see stale register-file data for queued writes.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `DATA_W`, 64: data width.
- `ADDR_W`, 5: register address width.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a write.
- `in_ready`  out  1  queue can accept.
- `in_addr`  in  ADDR_W  destination register.
- `in_data`  in  DATA_W  write data.
- `rf_hold`  in  1  register-file write port unavailable this cycle.
- `W`  out  1  register-file write enable.
- `DA`  out  ADDR_W  register-file destination address.
- `D`  out  DATA_W  register-file write data.
- `SA`  in  ADDR_W  register-file A read address (monitored).
- `SB`  in  ADDR_W  register-file B read address (monitored).
- `fwd_a_hit`  out  1  a queued write targets `SA`.
- `fwd_a_data`  out  DATA_W  youngest queued data for `SA`.
- `fwd_b_hit`  out  1  a queued write targets `SB`.
- `fwd_b_data`  out  DATA_W  youngest queued data for `SB`.
- `count`  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Push when `in_valid && in_ready`. `in_ready = (count != DEPTH)`, derived from registered state only; no combinational path from `in_valid`.
- Pop when `W`. `W = (count != 0) && !rf_hold`. `DA`/`D` come from the head entry. They are 0 when the queue is empty.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. A push is never accepted while the queue is full, even if a pop occurs in the same cycle.
- Pointers wrap modulo `DEPTH`. `count` saturates neither up nor down because the handshake prevents it.
- Ordering: strict FIFO. Multiple queued writes to the same address all commit in order.
- Forwarding:
  - Purely combinational over all valid entries, including the head being written this cycle.
  - Youngest matching entry wins.
  - The `in_*` inputs are not searched.
  - With no match, hit is 0 and data is 0.
- `rf_hold` only stalls draining. Pushes continue until full.

## Timing
- Latency: a write accepted at edge N drives `W` in cycle N+1 (if not held). The register file captures it at edge N+1.
- Forwarding covers every write from acceptance until the edge at which it commits.
- Reset (`reset` low, async): pointers and `count` are 0. Outputs: `W`=0, `DA`=0, `D`=0, `in_ready`=1, `fwd_*_hit`=0, `fwd_*_data`=0, `count`=0.
- Reset mid-operation discards all queued writes. Nothing reaches the register file.
- Entry storage need not be reset; valid tracking must be.

## Configuration
- `REGFILE_XZR_DISCARD_EN`:
  - Defined: address 31 is the zero register.
    - A push with `in_addr == 31` completes the handshake but is not enqueued, so `count` is unchanged.
    - `fwd_*_hit` is forced to 0 when `SA`/`SB` is 31.
  - Undefined: address 31 is an ordinary register and is queued and forwarded like any other.

## Structure
- Shared package `regfile_pkg`:
  - `REG_ADDR_W`=5, `REG_DATA_W`=64, `XZR_ADDR`=31.
  - Typedef `wq_entry_t` {addr, data}.
- One sub-module: `wq_fwd_lookup`. It performs the youngest-first priority match of one read address against the entry array plus valid vector, given the tail pointer. It is instantiated twice (A and B).

## Test plan
- Reset, then push addr 3/data 0x11 with `rf_hold`=0 -> next cycle `W`=1, `DA`=3, `D`=0x11. The following cycle `W`=0 and `count`=0.
- Hold `rf_hold`=1 and push 4 writes -> `count`=4, `in_ready`=0, a fifth `in_valid` is not accepted. Release hold -> 4 consecutive `W` pulses in push order.
- Queue addr 7=0xA then addr 7=0xB, `SA`=7 -> `fwd_a_hit`=1, `fwd_a_data`=0xB. `SB`=8 -> `fwd_b_hit`=0.
- Full queue, `rf_hold`=0, `in_valid` held -> exactly one pop per cycle. A push is accepted on each cycle `in_ready`=1. Pointers wrap with no lost or duplicated write over 12 writes.
- Drive `reset` low while 3 entries are queued -> `W`=0 and `count`=0 immediately, with no stale write after release.
- With `REGFILE_XZR_DISCARD_EN`, push addr 31 -> `in_ready` handshake completes, `count` stays 0, no `W`, and `SA`=31 gives no hit. Without the macro -> the write to 31 is queued and forwarded.
